sd_rr_fifo_sched: RTL and testbench

//  Round-robin drain scheduler for a bank of N srdy/drdy FIFOs (e.g. per-queue

---
 rtl/sd_rr_fifo_sched.sv | 125 ++++++++++++
 tb/tb_sd_rr_fifo_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_rr_fifo_sched.sv
// Round-robin drain scheduler: grants one source FIFO at a time for up to
// `burst` words, then rotates priority; output word held in a single register.
module sd_rr_fifo_sched #(
   parameter  int unsigned inputs = 4,
   parameter  int unsigned width  = 8,
   parameter  int unsigned burst  = 4,
   localparam int unsigned isz    = $clog2(inputs),
   localparam int unsigned bsz    = $clog2(burst + 1)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [inputs-1:0]       c_srdy,
   output logic [inputs-1:0]       c_drdy,
   input  logic [inputs*width-1:0] c_data,
   output logic                    p_srdy,
   input  logic                    p_drdy,
   output logic [width-1:0]        p_data,
   output logic [isz-1:0]          p_grant
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   state_e           state_q;
   logic [isz-1:0]   g_q;
   logic [isz-1:0]   ptr_q;
   logic [bsz-1:0]   cnt_q;
   logic             p_srdy_q;
   logic [width-1:0] p_data_q;
   logic [isz-1:0]   p_grant_q;

   logic             out_rdy;
   logic             xfer_in;
   logic             arb_found;
   logic [isz-1:0]   arb_idx;
   logic [isz:0]     arb_scan;
   logic [isz-1:0]   g_next;
   logic [bsz-1:0]   cnt_inc;
   logic             burst_done;
   logic [width-1:0] sel_data;

   assign out_rdy    = ~p_srdy_q | p_drdy;
   assign xfer_in    = (state_q == ST_GRANT) & c_srdy[g_q] & out_rdy;
   assign g_next     = (g_q == isz'(inputs - 1)) ? '0 : g_q + isz'(1);
   assign cnt_inc    = cnt_q + bsz'(1);
   assign burst_done = (cnt_inc == bsz'(burst));

   // First requester at or after ptr_q, wrapping at inputs-1.
   always_comb begin
      arb_found = 1'b0;
      arb_idx   = '0;
      arb_scan  = '0;
      for (int unsigned k = 0; k < inputs; k++) begin
         arb_scan = {1'b0, ptr_q} + (isz+1)'(k);
         if (arb_scan >= (isz+1)'(inputs))
            arb_scan = arb_scan - (isz+1)'(inputs);
         if (!arb_found && c_srdy[arb_scan[isz-1:0]]) begin
            arb_found = 1'b1;
            arb_idx   = arb_scan[isz-1:0];
         end
      end
   end

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < inputs; i++)
         if (g_q == isz'(i))
            sel_data = c_data[i*width +: width];
   end

   // At most one accept bit, only for the granted source.
   always_comb begin
      c_drdy = '0;
      if (state_q == ST_GRANT)
         c_drdy[g_q] = out_rdy;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         g_q       <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         p_srdy_q  <= 1'b0;
         p_data_q  <= '0;
         p_grant_q <= '0;
      end else begin
         p_srdy_q <= xfer_in | (p_srdy_q & ~p_drdy);
         if (xfer_in) begin
            p_data_q  <= sel_data;
            p_grant_q <= g_q;
         end
         case (state_q)
            ST_IDLE: begin
               if (arb_found) begin
                  g_q     <= arb_idx;
                  cnt_q   <= '0;
                  state_q <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (xfer_in) begin
                  cnt_q <= cnt_inc;
                  if (burst_done) begin
                     state_q <= ST_IDLE;
                     ptr_q   <= g_next;
                  end
               end else if (!c_srdy[g_q] && out_rdy) begin
                  // Source went empty with the output free: give up the grant.
                  state_q <= ST_IDLE;
                  ptr_q   <= g_next;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign p_srdy  = p_srdy_q;
   assign p_data  = p_data_q;
   assign p_grant = p_grant_q;

endmodule

// File: tb/tb_sd_rr_fifo_sched.sv
// Directed bench for sd_rr_fifo_sched with behavioural source FIFOs and a
// per-source in-order scoreboard on the output channel.
module tb_sd_rr_fifo_sched;

   localparam int unsigned N     = 4;
   localparam int unsigned W     = 8;
   localparam int unsigned BURST = 4;

   logic           clk;
   logic           reset_n;
   logic [N-1:0]   c_srdy;
   logic [N-1:0]   c_drdy;
   logic [N*W-1:0] c_data;
   logic           p_srdy;
   logic           p_drdy;
   logic [W-1:0]   p_data;
   logic [1:0]     p_grant;

   sd_rr_fifo_sched #(.inputs(N), .width(W), .burst(BURST)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .c_srdy  (c_srdy),
      .c_drdy  (c_drdy),
      .c_data  (c_data),
      .p_srdy  (p_srdy),
      .p_drdy  (p_drdy),
      .p_data  (p_data),
      .p_grant (p_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         errors = 0;
   int         checks = 0;
   int         avail  [N];
   int         nxt    [N];
   int         outseq [N];
   bit         en     [N];
   int         run;
   logic [1:0] gq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] word_of(input int src, input int seq);
      return W'(src * 64 + (seq % 64));
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         c_srdy[i]        = en[i] && (avail[i] > 0);
         c_data[i*W +: W] = word_of(i, nxt[i]);
      end
   endtask

   // One clock: sample handshakes mid-cycle, then advance the source models.
   task automatic tick();
      logic [N-1:0] fire;
      logic         ofire;
      logic [1:0]   og;
      @(negedge clk);
      chk("c_drdy_onehot", 32'($onehot0(c_drdy)), 32'd1);
      if (c_drdy == '0) run = 0;
      fire  = c_srdy & c_drdy;
      ofire = p_srdy & p_drdy;
      og    = p_grant;
      if (fire != '0) begin
         run++;
         chk("burst_len", 32'(run <= int'(BURST)), 32'd1);
      end
      if (ofire) begin
         chk("scoreboard", 32'(p_data), 32'(word_of(int'(og), outseq[og])));
         outseq[og]++;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
         if (fire[i]) begin
            avail[i]--;
            nxt[i]++;
         end
      if (ofire) gq.push_back(og);
      drive();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         avail[i] = 0;
         en[i]    = 1'b1;
      end
      drive();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < N; i++) outseq[i] = nxt[i];
      run = 0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [0:6]  pv1;
      int          dk1 [7];
      logic [0:23] pv2;
      int          base;

      p_drdy = 1'b1;
      for (int i = 0; i < N; i++) begin
         nxt[i]    = 0;
         outseq[i] = 0;
      end
      run = 0;
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         avail[i] = 0;
         en[i]    = 1'b1;
      end
      drive();
      #12;
      chk("rst_p_srdy", 32'(p_srdy), 32'd0);
      chk("rst_p_data", 32'(p_data), 32'd0);
      chk("rst_p_grant", 32'(p_grant), 32'd0);
      chk("rst_c_drdy", 32'(c_drdy), 32'd0);
      do_reset();

      // Test 1: lone source 2 with 6 words.
      avail[2] = 6;
      base     = nxt[2];
      drive();
      tick();
      chk("t1_grant_drdy", 32'(c_drdy), 32'h4);
      chk("t1_first_idle", 32'(p_srdy), 32'd0);
      pv1 = 7'b1111011;
      dk1 = '{0, 1, 2, 3, 3, 4, 5};
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("t1_p_srdy", 32'(p_srdy), 32'(pv1[k]));
         chk("t1_p_data", 32'(p_data), 32'(word_of(2, base + dk1[k])));
         chk("t1_p_grant", 32'(p_grant), 32'd2);
      end
      tick();
      chk("t1_done_srdy", 32'(p_srdy), 32'd0);
      chk("t1_done_drdy", 32'(c_drdy), 32'd0);

      // Test 2: all sources always ready.
      do_reset();
      for (int i = 0; i < N; i++) avail[i] = 100;
      drive();
      tick();
      gq.delete();
      pv2 = 24'b1111_0_1111_0_1111_0_1111_0_1111;
      for (int k = 0; k < 24; k++) begin
         tick();
         chk("t2_p_srdy", 32'(p_srdy), 32'(pv2[k]));
      end
      tick();
      chk("t2_word_count", 32'(gq.size() >= 20), 32'd1);
      for (int k = 0; k < 20; k++)
         if (k < gq.size())
            chk("t2_grant_order", 32'(gq[k]), 32'((k / 4) % 4));

      // Test 3: downstream stall during a grant on source 0.
      do_reset();
      avail[0] = 10;
      base     = nxt[0];
      drive();
      tick();
      tick();
      chk("t3_first_word", 32'(p_data), 32'(word_of(0, base)));
      p_drdy = 1'b0;
      #1;
      chk("t3_stall_drdy", 32'(c_drdy), 32'd0);
      repeat (5) begin
         tick();
         chk("t3_hold_srdy", 32'(p_srdy), 32'd1);
         chk("t3_hold_data", 32'(p_data), 32'(word_of(0, base)));
         chk("t3_hold_drdy", 32'(c_drdy), 32'd0);
      end
      p_drdy = 1'b1;
      #1;
      chk("t3_resume_drdy", 32'(c_drdy), 32'h1);
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("t3_resume_srdy", 32'(p_srdy), 32'd1);
         chk("t3_resume_data", 32'(p_data), 32'(word_of(0, base + k)));
      end
      repeat (12) tick();

      // Test 4: abandoned grant on source 1, then pointer rotation.
      do_reset();
      avail[1] = 2;
      drive();
      tick();
      chk("t4_grant1", 32'(c_drdy), 32'h2);
      avail[3] = 3;
      drive();
      repeat (3) tick();
      chk("t4_abandon", 32'(c_drdy), 32'd0);
      tick();
      chk("t4_grant3", 32'(c_drdy), 32'h8);
      avail[0] = 2;
      avail[1] = 2;
      drive();
      repeat (5) tick();
      chk("t4_grant0", 32'(c_drdy), 32'h1);
      repeat (12) tick();

      // Test 5: reset asserted mid-burst with a word in the output register.
      do_reset();
      avail[1] = 10;
      drive();
      tick();
      tick();
      chk("t5_pre_srdy", 32'(p_srdy), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_srdy", 32'(p_srdy), 32'd0);
      chk("t5_rst_data", 32'(p_data), 32'd0);
      chk("t5_rst_drdy", 32'(c_drdy), 32'd0);
      do_reset();
      avail[0] = 4;
      avail[2] = 4;
      drive();
      tick();
      chk("t5_first_grant", 32'(c_drdy), 32'h1);
      repeat (16) tick();

      // Test 6: random source and downstream readiness.
      do_reset();
      for (int i = 0; i < N; i++) avail[i] = 1000000;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 9) < 7);
         p_drdy = ($urandom_range(0, 9) < 6);
         drive();
         tick();
      end
      for (int i = 0; i < N; i++) en[i] = 1'b0;
      p_drdy = 1'b1;
      drive();
      repeat (10) tick();
      chk("t6_drained", 32'(p_srdy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
